// File: rtl/gpu_pixel_writer.sv
// gpu_pixel_writer: clips rasterizer pixels, queues them and issues one 32-bit bus write per pixel
// Ports: i_clock/i_reset_n (sync active-low); i_fb_* framebuffer geometry and pixel strobe;
//        i_color pixel data; i_clear_overflow clears o_overflow; o_full/o_idle FIFO/FSM status;
//        o_bus_* write request with i_bus_ready handshake.
module gpu_pixel_writer #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic [31:0] i_fb_base,
    input  logic [15:0] i_fb_stride,
    input  logic [9:0]  i_fb_width,
    input  logic [9:0]  i_fb_height,
    input  logic [31:0] i_color,
    input  logic [9:0]  i_fb_x,
    input  logic [9:0]  i_fb_y,
    input  logic        i_fb_wr,
    input  logic        i_clear_overflow,
    output logic        o_overflow,
    output logic        o_full,
    output logic        o_idle,
    output logic        o_bus_request,
    output logic        o_bus_rw,
    output logic [31:0] o_bus_address,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ready
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic [1:0] {IDLE, CALC, REQ} state_t;
    state_t state_q, state_d;
    logic [51:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [9:0] x_q, y_q;
    logic [31:0] c_q, addr_q, addr_d, wdata_q, wdata_d, offset;
    logic [25:0] prod;
    logic req_q, req_d, ovf_q, in_range, pop, push, drop;
    assign o_full = count_q == CW'(FIFO_DEPTH);
    assign o_idle = count_q == '0 && state_q == IDLE;
    assign in_range = i_fb_wr && i_fb_x < i_fb_width && i_fb_y < i_fb_height;
    assign pop = state_q == IDLE && count_q != '0;
    // a pop on the same edge frees the slot, so a full FIFO still accepts
    assign push = in_range && (!o_full || pop);
    assign drop = in_range && o_full && !pop;
    assign prod = 26'(y_q) * 26'(i_fb_stride);
    assign offset = ({6'd0, prod} + {22'd0, x_q}) << 2;
    assign o_overflow = ovf_q;
    assign o_bus_request = req_q;
    assign o_bus_rw = req_q;
    assign o_bus_address = addr_q;
    assign o_bus_wdata = wdata_q;
    always_ff @(posedge i_clock) begin
        state_q <= !i_reset_n ? IDLE : state_d;
    end
    always_comb begin
        state_d = state_q == IDLE ? (pop ? CALC : IDLE) :
                  state_q == CALC ? REQ : (i_bus_ready ? IDLE : REQ);
    end
    always_comb begin
        req_d = state_d == REQ;
        addr_d = state_q == CALC ? i_fb_base + offset : addr_q;
        wdata_d = state_q == CALC ? c_q : wdata_q;
    end
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
            ovf_q <= 1'b0;
            req_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PW'(push);
            rd_ptr_q <= rd_ptr_q + PW'(pop);
            count_q <= count_q + CW'(push) - CW'(pop);
            ovf_q <= drop || (ovf_q && !i_clear_overflow);
            req_q <= req_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
        end
    end
    always_ff @(posedge i_clock) begin
        if (push) mem_q[wr_ptr_q] <= {i_fb_x, i_fb_y, i_color};
        if (pop) {x_q, y_q, c_q} <= mem_q[rd_ptr_q];
    end
endmodule
